// File: rtl/muldiv_issue_ctrl.sv
// muldiv_issue_ctrl: CPU-side initiator for the iterative multiply/divide unit.
//
// Takes decoded MULT/DIV/MTHI/MTLO/MFHI/MFLO requests from the execute stage,
// forwards MULT/DIV to the unit over a valid/ready request channel, collects
// the result over a valid/ready result channel and commits it into the
// architectural HI/LO registers. The pipeline is stalled (req_ready low)
// from the cycle a MULT/DIV is accepted until its result has been committed.
//
// Ports:
//   clock, reset         rising-edge clock, async active-low reset
//   req_valid/req_ready  pipeline request handshake
//   req_op               0 MULT, 1 DIV, 2 MTHI, 3 MTLO, 4 MFHI, 5 MFLO, 6/7 reserved
//   req_sign             signed MULT/DIV
//   req_src0/req_src1    operands (src0 also carries MTHI/MTLO data)
//   rd_valid/rd_data     one-cycle MFHI/MFLO read-back
//   busy                 a MULT/DIV is outstanding
//   mdu_in_*             request channel to the unit (registered payload)
//   mdu_out_*            result channel from the unit (res0 -> LO, res1 -> HI)
//   hi, lo               architectural HI/LO
//   cancel               exception flush, present only with MULDIV_CANCEL_EN
//
// Build option: define MULDIV_CANCEL_EN to add the cancel input. A cancelled
// operation that already reached the unit is still drained from the result
// channel, but its result is dropped instead of written to HI/LO.
module muldiv_issue_ctrl #(
  parameter int         DATA_W = 32,
  parameter logic [1:0] OP_MUL = 2'd1,
  parameter logic [1:0] OP_DIV = 2'd2
) (
  input  logic              clock,
  input  logic              reset,
`ifdef MULDIV_CANCEL_EN
  input  logic              cancel,
`endif
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic              req_sign,
  input  logic [DATA_W-1:0] req_src0,
  input  logic [DATA_W-1:0] req_src1,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              mdu_in_valid,
  input  logic              mdu_in_ready,
  output logic [1:0]        mdu_in_op,
  output logic              mdu_in_sign,
  output logic [DATA_W-1:0] mdu_in_src0,
  output logic [DATA_W-1:0] mdu_in_src1,
  input  logic              mdu_out_valid,
  output logic              mdu_out_ready,
  input  logic [DATA_W-1:0] mdu_out_res0,
  input  logic [DATA_W-1:0] mdu_out_res1,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam logic [2:0] REQ_MULT = 3'd0;
  localparam logic [2:0] REQ_DIV  = 3'd1;
  localparam logic [2:0] REQ_MTHI = 3'd2;
  localparam logic [2:0] REQ_MTLO = 3'd3;
  localparam logic [2:0] REQ_MFHI = 3'd4;
  localparam logic [2:0] REQ_MFLO = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  typedef struct packed {
    logic [1:0]        op;
    logic              sign;
    logic [DATA_W-1:0] src0;
    logic [DATA_W-1:0] src1;
  } mdu_req_t;

  state_t   state_q, state_d;
  mdu_req_t req_q;
  logic     discard_q, discard_d;
  logic     cancel_w;
  logic     accept, is_muldiv, in_hs, out_hs, commit;

`ifdef MULDIV_CANCEL_EN
  assign cancel_w = cancel;
`else
  assign cancel_w = 1'b0;
`endif

  assign accept    = req_valid & req_ready;
  assign is_muldiv = (req_op == REQ_MULT) | (req_op == REQ_DIV);
  assign in_hs     = (state_q == S_ISSUE) & mdu_in_ready;
  assign out_hs    = (state_q == S_WAIT) & mdu_out_valid;
  // A cancel landing in the same cycle as the result also suppresses the write.
  assign commit    = out_hs & ~(discard_q | cancel_w);

  assign mdu_in_op   = req_q.op;
  assign mdu_in_sign = req_q.sign;
  assign mdu_in_src0 = req_q.src0;
  assign mdu_in_src1 = req_q.src1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    discard_d     = discard_q;
    req_ready     = 1'b0;
    busy          = 1'b1;
    mdu_in_valid  = 1'b0;
    mdu_out_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy      = 1'b0;
        req_ready = ~cancel_w;
        discard_d = 1'b0;
        if (accept && is_muldiv) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        mdu_in_valid = 1'b1;
        if (in_hs) begin
          // Already handed to the unit: must still drain its result.
          state_d   = S_WAIT;
          discard_d = cancel_w;
        end else if (cancel_w) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        mdu_out_ready = 1'b1;
        if (cancel_w) discard_d = 1'b1;
        if (out_hs) begin
          state_d   = S_IDLE;
          discard_d = 1'b0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        discard_d = 1'b0;
      end
    endcase
  end

  // Accept (IDLE only) and commit (WAIT only) can never coincide, so the
  // HI/LO writes below never collide.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_q    <= '0;
      hi       <= '0;
      lo       <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (accept) begin
        case (req_op)
          REQ_MULT, REQ_DIV: begin
            req_q.op   <= (req_op == REQ_DIV) ? OP_DIV : OP_MUL;
            req_q.sign <= req_sign;
            req_q.src0 <= req_src0;
            req_q.src1 <= req_src1;
          end
          REQ_MTHI: hi <= req_src0;
          REQ_MTLO: lo <= req_src0;
          REQ_MFHI: begin
            rd_data  <= hi;
            rd_valid <= 1'b1;
          end
          REQ_MFLO: begin
            rd_data  <= lo;
            rd_valid <= 1'b1;
          end
          default: ;
        endcase
      end
      if (commit) begin
        lo <= mdu_out_res0;
        hi <= mdu_out_res1;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Testbench for muldiv_issue_ctrl: directed scenarios plus randomized request
// streams. A behavioural unit model answers the request channel; expected
// payloads, commits and read-backs go into queues that a monitor drains.
module tb_muldiv_issue_ctrl;
  localparam int W = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_op = '0;
  logic          req_sign = 1'b0;
  logic [W-1:0]  req_src0 = '0, req_src1 = '0;
  logic          rd_valid;
  logic [W-1:0]  rd_data;
  logic          busy;
  logic          mdu_in_valid;
  logic          mdu_in_ready = 1'b0;
  logic [1:0]    mdu_in_op;
  logic          mdu_in_sign;
  logic [W-1:0]  mdu_in_src0, mdu_in_src1;
  logic          mdu_out_valid = 1'b0;
  logic          mdu_out_ready;
  logic [W-1:0]  mdu_out_res0 = '0, mdu_out_res1 = '0;
  logic [W-1:0]  hi, lo;
`ifdef MULDIV_CANCEL_EN
  logic          cancel = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  muldiv_issue_ctrl dut (
    .clock(clock), .reset(reset),
`ifdef MULDIV_CANCEL_EN
    .cancel(cancel),
`endif
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_sign(req_sign), .req_src0(req_src0), .req_src1(req_src1),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
    .mdu_in_valid(mdu_in_valid), .mdu_in_ready(mdu_in_ready),
    .mdu_in_op(mdu_in_op), .mdu_in_sign(mdu_in_sign),
    .mdu_in_src0(mdu_in_src0), .mdu_in_src1(mdu_in_src1),
    .mdu_out_valid(mdu_out_valid), .mdu_out_ready(mdu_out_ready),
    .mdu_out_res0(mdu_out_res0), .mdu_out_res1(mdu_out_res1),
    .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string why);
    checks++;
    failures++;
    $display("FAIL %s: %s", name, why);
  endtask

  // Architectural result: {HI, LO} = {rem, quot} for DIV, 64-bit product for MULT.
  function automatic logic [63:0] calc(input bit is_div, input bit sg,
                                       input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    if (!is_div) return 64'(sa * sb);
    return {32'(sa % sb), 32'(sa / sb)};
  endfunction

  typedef struct packed {
    logic [1:0]  op;
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
  } iss_t;

  iss_t         iss_q[$];
  logic [63:0]  com_q[$];
  logic [31:0]  rd_q[$];
  logic [31:0]  ref_hi = '0, ref_lo = '0;

  // ---------------- behavioural multiply/divide unit ----------------
  int lat = 4;          // cycles from request handshake to out_valid
  int stall_left = 0;   // in_ready held low for this many offered cycles
  bit rnd_mode = 0;
  int u_cnt = 0;
  bit u_pend = 0;

  initial forever begin
    bit hs_in, hs_out, inv;
    logic [63:0] r;
    @(negedge clock);
    hs_in  = mdu_in_valid && mdu_in_ready;
    hs_out = mdu_out_valid && mdu_out_ready;
    inv    = mdu_in_valid;
    r      = calc(mdu_in_op == 2'd2, mdu_in_sign, mdu_in_src0, mdu_in_src1);
    @(posedge clock); #1;
    if (!reset) begin
      u_pend = 0;
      mdu_out_valid = 1'b0;
    end else begin
      if (hs_out) begin
        mdu_out_valid = 1'b0;
        u_pend = 0;
      end
      if (hs_in) begin
        mdu_out_res0 = r[31:0];
        mdu_out_res1 = r[63:32];
        u_pend = 1;
        u_cnt  = rnd_mode ? int'($urandom_range(1, 6)) : lat;
        if (rnd_mode) stall_left = int'($urandom_range(0, 2));
      end else if (u_pend && !mdu_out_valid) begin
        u_cnt--;
        if (u_cnt == 0) mdu_out_valid = 1'b1;
      end
      if (inv && !hs_in && stall_left > 0) stall_left--;
    end
    mdu_in_ready = !u_pend && stall_left == 0;
  end

  // ---------------- monitor / scoreboard ----------------
  bit   com_pend = 0;
  bit   prev_stall = 0;
  iss_t prev_pl;

  initial forever begin
    iss_t cur, e;
    logic [63:0] ce;
    logic [31:0] re;
    @(negedge clock);
    if (!reset) begin
      com_pend = 0;
      prev_stall = 0;
    end else begin
      if (com_pend) begin
        com_pend = 0;
        if (com_q.size() == 0) fail_now("commit_unexpected", "result consumed with no commit expected");
        else begin
          ce = com_q.pop_front();
          chk("commit_hi", hi, ce[63:32]);
          chk("commit_lo", lo, ce[31:0]);
        end
      end
      if (mdu_out_valid && mdu_out_ready) com_pend = 1;
      if (mdu_in_valid) begin
        cur = '{mdu_in_op, mdu_in_sign, mdu_in_src0, mdu_in_src1};
        if (prev_stall) chk("payload_stable", cur[63:0] ^ {cur[66:64], 61'b0}, prev_pl[63:0] ^ {prev_pl[66:64], 61'b0});
        if (mdu_in_ready) begin
          prev_stall = 0;
          if (iss_q.size() == 0) fail_now("issue_unexpected", "request offered with none expected");
          else begin
            e = iss_q.pop_front();
            chk("in_op", mdu_in_op, e.op);
            chk("in_sign", mdu_in_sign, e.sg);
            chk("in_src", {mdu_in_src0, mdu_in_src1}, {e.a, e.b});
          end
        end else begin
          prev_stall = 1;
          prev_pl = cur;
        end
      end else prev_stall = 0;
      if (rd_valid) begin
        if (rd_q.size() == 0) fail_now("rd_unexpected", "rd_valid with no read expected");
        else begin
          re = rd_q.pop_front();
          chk("rd_data", rd_data, re);
        end
      end
    end
  end

  int busy_seen = 0;
  always @(negedge clock) if (busy) busy_seen++;

  // ---------------- stimulus ----------------
  // Called at posedge+1; returns at posedge+1 just after the acceptance edge.
  task automatic do_req(input logic [2:0] op, input logic sg, input logic [31:0] a,
                        input logic [31:0] b, output int waited);
    logic [63:0] r;
    iss_t it;
    req_valid = 1'b1; req_op = op; req_sign = sg; req_src0 = a; req_src1 = b;
    waited = 0;
    forever begin
      @(negedge clock);
      if (req_ready) break;
      waited++;
      if (waited > 300) begin
        fail_now("accept_timeout", "req_ready never rose");
        break;
      end
    end
    @(posedge clock); #1;
    req_valid = 1'b0;
    case (op)
      3'd0, 3'd1: begin
        r = calc(op == 3'd1, sg, a, b);
        it = '{(op == 3'd1) ? 2'd2 : 2'd1, sg, a, b};
        iss_q.push_back(it);
        com_q.push_back(r);
        ref_hi = r[63:32];
        ref_lo = r[31:0];
      end
      3'd2: ref_hi = a;
      3'd3: ref_lo = a;
      3'd4: rd_q.push_back(ref_hi);
      3'd5: rd_q.push_back(ref_lo);
      default: ;
    endcase
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (busy) fail_now("idle_timeout", "busy never dropped");
    @(posedge clock); #1;
  endtask

  initial begin
    int w, n, b0;
    logic [2:0] op;
    logic [31:0] a, b;

    #12;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_rd", {rd_valid, rd_data}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_valid", mdu_in_valid, 0);
    chk("rst_out_ready", mdu_out_ready, 0);
    chk("rst_in_payload", {mdu_in_op, mdu_in_sign, mdu_in_src0[28:0], mdu_in_src1}, 0);
    chk("rst_req_ready", req_ready, 1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

    // signed DIV -7 / 2, 8-cycle unit
    lat = 8;
    do_req(3'd1, 1'b1, 32'hFFFFFFF9, 32'd2, w);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (!busy) break;
      n++;
    end
    chk("t1_busy_cycles", n, 10);
    @(posedge clock); #1;
    chk("t1_lo", lo, 32'hFFFFFFFD);
    chk("t1_hi", hi, 32'hFFFFFFFF);

    // unsigned MULT with in_ready held off 3 cycles
    lat = 3;
    stall_left = 3;
    do_req(3'd0, 1'b0, 32'hFFFFFFFF, 32'd2, w);
    wait_idle();
    chk("t2_hi", hi, 32'h00000001);
    chk("t2_lo", lo, 32'hFFFFFFFE);

    // MTLO then MFLO back-to-back
    b0 = busy_seen;
    do_req(3'd3, 1'b0, 32'h12345678, 32'd0, w);
    do_req(3'd5, 1'b0, 32'd0, 32'd0, w);
    @(posedge clock); #1;
    chk("t3_busy_seen", busy_seen - b0, 0);
    chk("t3_lo", lo, 32'h12345678);

    // DIV then MFHI stalled behind it
    lat = 8;
    do_req(3'd1, 1'b0, 32'd100, 32'd7, w);
    do_req(3'd4, 1'b0, 32'd0, 32'd0, w);
    chk("t4_mfhi_wait", w, 10);
    @(posedge clock); #1;

    // reset while waiting on the unit
    do_req(3'd0, 1'b0, 32'd1234, 32'd5678, w);
    n = 0;
    while (!mdu_out_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("t5_in_wait", mdu_out_ready, 1);
    #2 reset = 1'b0;
    #1;
    chk("t5_hi", hi, 0);
    chk("t5_lo", lo, 0);
    chk("t5_busy", busy, 0);
    chk("t5_out_ready", mdu_out_ready, 0);
    chk("t5_in_valid", mdu_in_valid, 0);
    chk("t5_payload", {mdu_in_op, mdu_in_sign, mdu_in_src0[28:0], mdu_in_src1}, 0);
    iss_q.delete(); com_q.delete(); rd_q.delete();
    ref_hi = '0; ref_lo = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    lat = 2;
    do_req(3'd0, 1'b0, 32'd3, 32'd5, w);
    wait_idle();
    chk("t5_mul_lo", lo, 32'd15);
    chk("t5_mul_hi", hi, 32'd0);

`ifdef MULDIV_CANCEL_EN
    do_req(3'd2, 1'b0, 32'hAAAAAAAA, 32'd0, w);
    do_req(3'd3, 1'b0, 32'hAAAAAAAA, 32'd0, w);
    lat = 8;
    do_req(3'd1, 1'b0, 32'd100, 32'd7, w);
    void'(com_q.pop_back());
    com_q.push_back({32'hAAAAAAAA, 32'hAAAAAAAA});
    ref_hi = 32'hAAAAAAAA;
    ref_lo = 32'hAAAAAAAA;
    n = 0;
    while (!mdu_out_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    @(posedge clock); #1 cancel = 1'b1;
    @(posedge clock); #1 cancel = 1'b0;
    wait_idle();
    chk("cx_hi", hi, 32'hAAAAAAAA);
    chk("cx_lo", lo, 32'hAAAAAAAA);
`endif

    // randomized request stream
    rnd_mode = 1;
    for (int i = 0; i < 80; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if (op == 3'd1 && b == 32'd0) b = 32'd1;
      do_req(op, 1'($urandom_range(0, 1)), a, b, w);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock); #1;
      end
    end
    wait_idle();
    repeat (3) @(posedge clock);
    chk("sb_drain", iss_q.size() + com_q.size() + rd_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/muldiv_issue_ctrl.md
Name: muldiv_issue_ctrl

Overview:
- CPU-side initiator for the iterative multiply/divide unit.
- Accepts decoded MULT/DIV/MTHI/MTLO/MFHI/MFLO requests from the execute stage and drives the unit's in_valid/in_ready request channel and out_valid/out_ready result channel.
- Commits results into architectural HI/LO registers.
- Back-pressures the pipeline while an operation is outstanding.

Parameters:
- DATA_W, 32, operand/result width; must match the unit.
- OP_MUL, 2'd1, in_op code driven for multiply.
- OP_DIV, 2'd2, in_op code driven for divide.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  pipeline request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_op  in  3  0 MULT, 1 DIV, 2 MTHI, 3 MTLO, 4 MFHI, 5 MFLO; 6/7 reserved.
- req_sign  in  1  signed MULT/DIV.
- req_src0  in  DATA_W  dividend / multiplicand / MT data.
- req_src1  in  DATA_W  divisor / multiplier.
- rd_valid  out  1  one-cycle pulse: rd_data holds MFHI/MFLO result.
- rd_data  out  DATA_W  HI or LO read data.
- busy  out  1  mul/div outstanding.
- mdu_in_valid  out  1  request to unit.
- mdu_in_ready  in  1  unit can accept.
- mdu_in_op  out  2  OP_MUL or OP_DIV.
- mdu_in_sign  out  1  registered req_sign.
- mdu_in_src0  out  DATA_W  registered operand 0.
- mdu_in_src1  out  DATA_W  registered operand 1.
- mdu_out_valid  in  1  unit result valid.
- mdu_out_ready  out  1  controller takes result.
- mdu_out_res0  in  DATA_W  LO part: product low / quotient.
- mdu_out_res1  in  DATA_W  HI part: product high / remainder.
- hi  out  DATA_W  architectural HI.
- lo  out  DATA_W  architectural LO.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE.
  - hi, lo, rd_data, mdu_in_src0/1 = 0.
  - mdu_in_op=0, mdu_in_sign=0.
  - rd_valid, mdu_in_valid, mdu_out_ready, busy = 0.
- States: IDLE, ISSUE, WAIT.
- req_ready = (state==IDLE). busy = (state!=IDLE).
- IDLE, accepted MULT/DIV:
  - Latch operands, sign and op code into mdu_in_* registers.
  - Go to ISSUE next cycle.
- ISSUE:
  - mdu_in_valid=1 with stable payload.
  - On mdu_in_valid & mdu_in_ready: go to WAIT; mdu_in_valid drops the next cycle.
  - Payload must not change while waiting.
- WAIT:
  - mdu_out_ready=1.
  - On mdu_out_valid: lo<=mdu_out_res0, hi<=mdu_out_res1 at that edge; go to IDLE.
  - req_ready rises the following cycle.
- MTHI/MTLO accepted in IDLE: hi (resp. lo) <= req_src0 at the same edge; state stays IDLE; single-cycle.
- MFHI/MFLO accepted in IDLE: rd_data <= hi/lo; rd_valid=1 for exactly the next cycle.
  - MFHI/MFLO right after MTHI/MTLO returns the newly written value.
- Any request arriving while busy stalls (req_ready=0); it is never dropped.
- Latency from accepted MULT/DIV to req_ready high = 2 + unit latency cycles.
- Reserved req_op values: accepted, no effect, no rd_valid.
- mdu_out_valid outside WAIT: ignored; mdu_out_ready stays 0.
- Reset mid-operation:
  - Controller returns to IDLE immediately.
  - hi/lo cleared.
  - The unit is reset by the same reset.

Optional Feature:
- Macro: MULDIV_CANCEL_EN.
- Defined: adds input port cancel (1 bit) for exception flush.
  - cancel in ISSUE: mdu_in_valid deasserts next cycle; go to IDLE; hi/lo unchanged.
  - cancel in ISSUE in the same cycle as the handshake: go to WAIT with discard flag set.
  - cancel in WAIT: discard flag set.
  - While discard is set, mdu_out_ready stays 1; the result is consumed without writing hi/lo; flag clears on return to IDLE.
  - cancel in IDLE: blocks acceptance of that cycle's request.
- Not defined: no cancel port; every issued operation commits.

Test Plan:
- Signed DIV src0=0xFFFFFFF9 (-7), src1=2, unit model 8-cycle latency -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; busy high exactly 10 cycles.
- Unsigned MULT 0xFFFFFFFF x 2, mdu_in_ready low for 3 cycles -> payload stable while waiting; afterwards hi=0x00000001, lo=0xFFFFFFFE.
- MTLO 0x12345678 then MFLO back-to-back -> rd_valid pulse with rd_data=0x12345678; busy never asserted.
- DIV issued then MFHI held valid -> req_ready low until 1 cycle after mdu_out_valid; MFHI then returns the remainder.
- Assert reset in WAIT -> all outputs 0 asynchronously; new MULT 3x5 after release -> lo=15, hi=0.
- With MULDIV_CANCEL_EN: cancel in WAIT of DIV 100/7 with hi=lo=0xAAAAAAAA beforehand -> result consumed, hi/lo remain 0xAAAAAAAA.
